// File: rtl/pong_pkg.sv
// Shared definitions for the pong sequencer and datapath: FSM state encoding
// and default timing/score parameters.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_SCORED    = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int DEF_TICK_DIV   = 16;
   localparam int DEF_SCORE_W    = 4;
   localparam int DEF_WIN_SCORE  = 7;
   localparam int DEF_HOLD_TICKS = 4;

endpackage

// File: rtl/pong_tick_divider.sv
// Free-running 0..TICK_DIV-1 counter with hold (enable low) and synchronous clear.
// o_wrap marks the enabled cycle on which the count rolls over.
module pong_tick_divider #(
   parameter int TICK_DIV = pong_pkg::DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clear,
   output logic o_wrap
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
      end
   end

   assign o_wrap = i_en & (r_count == LAST);

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game flow controller: serve/play/score/game-over FSM, score keeping and
// the datapath tick strobe derived from the system clock.
module pong_game_sequencer
   import pong_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int SCORE_W    = DEF_SCORE_W,
   parameter int WIN_SCORE  = DEF_WIN_SCORE,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pause,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               tick_en,
   output logic               dp_load,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic [2:0]         game_state,
   output logic               game_over
);

   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
   localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_TICKS - 1);

   state_t             r_state, w_state_nxt;
   logic [SCORE_W-1:0] r_score_left, w_score_left_nxt;
   logic [SCORE_W-1:0] r_score_right, w_score_right_nxt;
   logic               r_serve_dir, w_serve_dir_nxt;
   logic [HW-1:0]      r_hold, w_hold_nxt;
   logic               w_active;
   logic               w_wrap;

   // Divider only runs during a rally or the post-point hold; a pause freezes its phase.
   assign w_active = (r_state == ST_PLAY) || (r_state == ST_SCORED);

   pong_tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_active & ~pause),
      .i_clear (~w_active),
      .o_wrap  (w_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_score_left  <= '0;
         r_score_right <= '0;
         r_serve_dir   <= 1'b1;
         r_hold        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_score_left  <= w_score_left_nxt;
         r_score_right <= w_score_right_nxt;
         r_serve_dir   <= w_serve_dir_nxt;
         r_hold        <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_score_left_nxt  = r_score_left;
      w_score_right_nxt = r_score_right;
      w_serve_dir_nxt   = r_serve_dir;
      w_hold_nxt        = r_hold;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_SERVE;
         end
         ST_SERVE: begin
            w_state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            // A simultaneous miss on both edges is a dead ball: re-serve without scoring.
            if (miss_left && !miss_right) begin
               if (r_score_right < WIN) w_score_right_nxt = r_score_right + 1'b1;
               w_serve_dir_nxt = 1'b0;
               w_state_nxt     = ST_SCORED;
            end else if (miss_right && !miss_left) begin
               if (r_score_left < WIN) w_score_left_nxt = r_score_left + 1'b1;
               w_serve_dir_nxt = 1'b1;
               w_state_nxt     = ST_SCORED;
            end else if (miss_left && miss_right) begin
               w_state_nxt = ST_SCORED;
            end
         end
         ST_SCORED: begin
            if (w_wrap) begin
               if (r_hold == HOLD_LAST) begin
                  w_hold_nxt  = '0;
                  w_state_nxt = ((r_score_left == WIN) || (r_score_right == WIN)) ?
                                ST_GAME_OVER : ST_SERVE;
               end else begin
                  w_hold_nxt = r_hold + 1'b1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (start) begin
               w_score_left_nxt  = '0;
               w_score_right_nxt = '0;
               w_serve_dir_nxt   = 1'b1;
               w_state_nxt       = ST_SERVE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign tick_en     = (r_state == ST_PLAY) & w_wrap;
   assign dp_load     = (r_state == ST_SERVE);
   assign game_over   = (r_state == ST_GAME_OVER);
   assign serve_dir   = r_serve_dir;
   assign score_left  = r_score_left;
   assign score_right = r_score_right;
   assign game_state  = r_state;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed game scenarios followed by randomized play, checked every cycle against
// a behavioural game model.
module tb_pong_game_sequencer;

   localparam int TD   = 4;
   localparam int SW   = 4;
   localparam int WIN  = 2;
   localparam int HOLD = 2;

   // model state numbering follows the published state encoding
   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_SCORED = 3, M_OVER = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, pause, miss_left, miss_right;
   logic          tick_en, dp_load, serve_dir, game_over;
   logic [SW-1:0] score_left, score_right;
   logic [2:0]    game_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int m_st, m_div, m_hold, m_sl, m_sr, m_sd;
   logic [14:0] exp_q[$];

   pong_game_sequencer #(
      .TICK_DIV   (TD),
      .SCORE_W    (SW),
      .WIN_SCORE  (WIN),
      .HOLD_TICKS (HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pause       (pause),
      .miss_left   (miss_left),
      .miss_right  (miss_right),
      .tick_en     (tick_en),
      .dp_load     (dp_load),
      .serve_dir   (serve_dir),
      .score_left  (score_left),
      .score_right (score_right),
      .game_state  (game_state),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_div = 0; m_hold = 0; m_sl = 0; m_sr = 0; m_sd = 1;
   endtask

   function automatic bit model_wrap(input logic p);
      return (m_div == TD - 1) && !p;
   endfunction

   function automatic logic [14:0] model_outputs(input logic p);
      logic t;
      t = (m_st == M_PLAY) && model_wrap(p);
      return {t, logic'(m_st == M_SERVE), logic'(m_sd[0]), 4'(m_sl), 4'(m_sr),
              3'(m_st), logic'(m_st == M_OVER)};
   endfunction

   task automatic model_step(input logic s, input logic p, input logic ml, input logic mr);
      bit w;
      bit run;
      w   = model_wrap(p);
      run = (m_st == M_PLAY) || (m_st == M_SCORED);
      case (m_st)
         M_IDLE:  if (s) m_st = M_SERVE;
         M_SERVE: m_st = M_PLAY;
         M_PLAY: begin
            if (ml && !mr) begin
               m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_sd = 0; m_st = M_SCORED;
            end else if (mr && !ml) begin
               m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_sd = 1; m_st = M_SCORED;
            end else if (ml && mr) begin
               m_st = M_SCORED;
            end
         end
         M_SCORED: begin
            if (w) begin
               m_hold = m_hold + 1;
               if (m_hold == HOLD) begin
                  m_hold = 0;
                  m_st = (m_sl == WIN || m_sr == WIN) ? M_OVER : M_SERVE;
               end
            end
         end
         M_OVER: if (s) begin m_sl = 0; m_sr = 0; m_sd = 1; m_st = M_SERVE; end
         default: m_st = M_IDLE;
      endcase
      if (!run)   m_div = 0;
      else if (!p) m_div = (m_div + 1) % TD;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic drive_cycle(input logic s, input logic p, input logic ml,
                              input logic mr, input logic rn);
      logic [14:0] e;
      start = s; pause = p; miss_left = ml; miss_right = mr; rst_n = rn;
      if (!rn) model_reset();
      exp_q.push_back(model_outputs(p));
      #1;
      e = exp_q.pop_front();
      check_val("tick_en",     32'(tick_en),     32'(e[14]));
      check_val("dp_load",     32'(dp_load),     32'(e[13]));
      check_val("serve_dir",   32'(serve_dir),   32'(e[12]));
      check_val("score_left",  32'(score_left),  32'(e[11:8]));
      check_val("score_right", 32'(score_right), 32'(e[7:4]));
      check_val("game_state",  32'(game_state),  32'(e[3:1]));
      check_val("game_over",   32'(game_over),   32'(e[0]));
      @(posedge clk);
      if (rn) model_step(s, p, ml, mr);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int  pause_left;
      logic s, p, ml, mr, rn;
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
      model_reset();
      @(negedge clk);

      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("rst_state", 32'(game_state), 32'd0);
      check_val("rst_serve_dir", 32'(serve_dir), 32'd1);

      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_cycles(10);
      check_val("t1_play", 32'(game_state), 32'd2);

      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t2_scored", 32'(game_state), 32'd3);
      idle_cycles(12);
      check_val("t2_score_left", 32'(score_left), 32'd1);

      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(6);

      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle_cycles(12);
      check_val("t4_score_right", 32'(score_right), 32'd0);

      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle_cycles(12);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle_cycles(12);
      check_val("t5_game_over", 32'(game_over), 32'd1);
      check_val("t5_score_right", 32'(score_right), 32'd2);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("t5_serve", 32'(game_state), 32'd1);
      check_val("t5_cleared", 32'(score_right), 32'd0);

      idle_cycles(2);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle_cycles(3);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(10);
      check_val("t6_idle", 32'(game_state), 32'd0);
      check_val("t6_score_left", 32'(score_left), 32'd0);

      pause_left = 0;
      for (int c = 0; c < 3000; c++) begin
         rn = ($urandom_range(0, 399) != 0);
         if (pause_left > 0) begin
            p = 1'b1;
            pause_left--;
         end else begin
            p = 1'b0;
            if ($urandom_range(0, 29) == 0) pause_left = $urandom_range(1, 12);
         end
         s  = ($urandom_range(0, 15) == 0);
         ml = ($urandom_range(0, 11) == 0);
         mr = ($urandom_range(0, 11) == 0);
         drive_cycle(s, p, ml, mr, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
